// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    // Encoding must match the execute-stage operand mux.
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forwarding comparator for one ALU operand; purely combinational.
module fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] src,
    input  logic       exmem_regwrite,
    input  logic [4:0] exmem_dest,
    input  logic       memwb_regwrite,
    input  logic [4:0] memwb_dest,
    output logic [1:0] sel
);

    logic hit_mem;
    logic hit_wb;

    // r0 is hard-wired zero, so a write to it must never be forwarded.
    assign hit_mem = exmem_regwrite & (exmem_dest != 5'd0) & (exmem_dest == src);
    assign hit_wb  = memwb_regwrite & (memwb_dest != 5'd0) & (memwb_dest == src);

    // The younger EX/MEM result wins over MEM/WB.
    assign sel = hit_mem ? FWD_MEM : (hit_wb ? FWD_WB : FWD_REG);

endmodule

// File: rtl/hazard_ctrl.sv
// Forwarding, load-use stall and taken-branch flush control for the 5-stage core.
// Optional event counters are enabled by defining HAZARD_STATS_EN.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned LOAD_STALL = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic [4:0]  idex_rs,
    input  logic [4:0]  idex_rt,
    input  logic        idex_memread,
    input  logic [4:0]  idex_dest,
    input  logic        exmem_regwrite,
    input  logic [4:0]  exmem_dest,
    input  logic        memwb_regwrite,
    input  logic [4:0]  memwb_dest,
    input  logic        exmem_branch,
    input  logic        exmem_zero,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        idex_bubble,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        flush_exmem,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    logic       take;
    logic       load_use;
    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    assign take     = exmem_branch & exmem_zero;
    assign load_use = idex_memread & (idex_dest != 5'd0) &
                      ((idex_dest == id_rs) | (id_uses_rt & (idex_dest == id_rt)));

    fwd_sel u_fwd_a (
        .src            (idex_rs),
        .exmem_regwrite (exmem_regwrite),
        .exmem_dest     (exmem_dest),
        .memwb_regwrite (memwb_regwrite),
        .memwb_dest     (memwb_dest),
        .sel            (fwd_a)
    );

    fwd_sel u_fwd_b (
        .src            (idex_rt),
        .exmem_regwrite (exmem_regwrite),
        .exmem_dest     (exmem_dest),
        .memwb_regwrite (memwb_regwrite),
        .memwb_dest     (memwb_dest),
        .sel            (fwd_b)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_exmem = 1'b0;
        // A taken branch squashes the stalled instruction, so it overrides any hazard.
        if (take) begin
            flush_ifid  = 1'b1;
            flush_idex  = 1'b1;
            flush_exmem = 1'b1;
            state_d     = RUN;
            cnt_d       = 3'd0;
        end else begin
            case (state_q)
                RUN: begin
                    if (load_use) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        if (LOAD_STALL > 1) begin
                            state_d = STALL;
                            cnt_d   = 3'(LOAD_STALL - 1);
                        end
                    end
                end
                STALL: begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    cnt_d       = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            if (!pc_write && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (take && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`else
    assign stall_count = 16'd0;
    assign flush_count = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with LOAD_STALL=1 and LOAD_STALL=3 instances.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] id_rs, id_rt, idex_rs, idex_rt, idex_dest, exmem_dest, memwb_dest;
    logic id_uses_rt, idex_memread, exmem_regwrite, memwb_regwrite, exmem_branch, exmem_zero;

    logic [1:0]  fa1, fb1, fa3, fb3;
    logic        pw1, iw1, bb1, fi1, fd1, fe1;
    logic        pw3, iw3, bb3, fi3, fd3, fe3;
    logic [15:0] sc1, fc1, sc3, fc3;

    logic [5:0] ctl1, ctl3;
    assign ctl1 = {pw1, iw1, bb1, fi1, fd1, fe1};
    assign ctl3 = {pw3, iw3, bb3, fi3, fd3, fe3};

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_STALL(1)) dut1 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_memread(idex_memread), .idex_dest(idex_dest),
        .exmem_regwrite(exmem_regwrite), .exmem_dest(exmem_dest),
        .memwb_regwrite(memwb_regwrite), .memwb_dest(memwb_dest),
        .exmem_branch(exmem_branch), .exmem_zero(exmem_zero),
        .fwd_a(fa1), .fwd_b(fb1), .pc_write(pw1), .ifid_write(iw1), .idex_bubble(bb1),
        .flush_ifid(fi1), .flush_idex(fd1), .flush_exmem(fe1),
        .stall_count(sc1), .flush_count(fc1)
    );

    hazard_ctrl #(.LOAD_STALL(3)) dut3 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_memread(idex_memread), .idex_dest(idex_dest),
        .exmem_regwrite(exmem_regwrite), .exmem_dest(exmem_dest),
        .memwb_regwrite(memwb_regwrite), .memwb_dest(memwb_dest),
        .exmem_branch(exmem_branch), .exmem_zero(exmem_zero),
        .fwd_a(fa3), .fwd_b(fb3), .pc_write(pw3), .ifid_write(iw3), .idex_bubble(bb3),
        .flush_ifid(fi3), .flush_idex(fd3), .flush_exmem(fe3),
        .stall_count(sc3), .flush_count(fc3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        idex_rs = 5'd0; idex_rt = 5'd0; idex_memread = 1'b0; idex_dest = 5'd0;
        exmem_regwrite = 1'b0; exmem_dest = 5'd0; memwb_regwrite = 1'b0; memwb_dest = 5'd0;
        exmem_branch = 1'b0; exmem_zero = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic hazard_on();
        idex_memread = 1'b1; idex_dest = 5'd8; id_rs = 5'd8;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({fa1, fb1, ctl1} !== 10'b0000_110000) $display("FAIL reset_ctl1: got %b want 0000110000", {fa1, fb1, ctl1});
        else n_pass++;
        n_checks++;
        if ({fa3, fb3, ctl3} !== 10'b0000_110000) $display("FAIL reset_ctl3: got %b want 0000110000", {fa3, fb3, ctl3});
        else n_pass++;
        n_checks++;
        if ({sc1, fc1, sc3, fc3} !== 64'd0) $display("FAIL reset_counters: got %h want 0", {sc1, fc1, sc3, fc3});
        else n_pass++;
    endtask

    task automatic test_forward();
        // rs, rt, ex_rw, ex_dest, wb_rw, wb_dest, expected {fwd_a, fwd_b}
        logic [4:0] rs_v [7] = '{5'd5, 5'd5, 5'd3, 5'd9, 5'd0, 5'd12, 5'd31};
        logic [4:0] rt_v [7] = '{5'd0, 5'd0, 5'd7, 5'd9, 5'd0, 5'd4,  5'd31};
        logic       exw_v[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1,  1'b0};
        logic [4:0] exd_v[7] = '{5'd5, 5'd0, 5'd3, 5'd9, 5'd0, 5'd4,  5'd31};
        logic       wbw_v[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,  1'b0};
        logic [4:0] wbd_v[7] = '{5'd5, 5'd5, 5'd7, 5'd9, 5'd0, 5'd12, 5'd31};
        logic [3:0] exp_v[7] = '{4'b1000, 4'b0100, 4'b0001, 4'b1010, 4'b0000, 4'b0110, 4'b0000};
        for (int i = 0; i < 7; i++) begin
            idex_rs = rs_v[i]; idex_rt = rt_v[i];
            exmem_regwrite = exw_v[i]; exmem_dest = exd_v[i];
            memwb_regwrite = wbw_v[i]; memwb_dest = wbd_v[i];
            #1;
            n_checks++;
            if ({fa1, fb1} !== exp_v[i]) $display("FAIL fwd_vec%0d: got %b want %b", i, {fa1, fb1}, exp_v[i]);
            else n_pass++;
            n_checks++;
            if ({fa3, fb3} !== exp_v[i]) $display("FAIL fwd3_vec%0d: got %b want %b", i, {fa3, fb3}, exp_v[i]);
            else n_pass++;
        end
        idle();
    endtask

    task automatic test_load_use_1();
        do_reset();
        hazard_on();
        #1;
        n_checks++;
        if (ctl1 !== 6'b001000) $display("FAIL lu1_stall: got %b want 001000", ctl1);
        else n_pass++;
        tick();
        idex_memread = 1'b0;
        #1;
        n_checks++;
        if (ctl1 !== 6'b110000) $display("FAIL lu1_release: got %b want 110000", ctl1);
        else n_pass++;

        do_reset();
        idex_memread = 1'b1; idex_dest = 5'd8; id_rs = 5'd2; id_rt = 5'd8; id_uses_rt = 1'b0;
        #1;
        n_checks++;
        if ({pw1, pw3} !== 2'b11) $display("FAIL lu_rt_unused: got %b want 11", {pw1, pw3});
        else n_pass++;
        id_uses_rt = 1'b1;
        #1;
        n_checks++;
        if ({pw1, bb1} !== 2'b01) $display("FAIL lu_rt_used: got %b want 01", {pw1, bb1});
        else n_pass++;
        id_uses_rt = 1'b0; idex_dest = 5'd0; id_rs = 5'd0;
        #1;
        n_checks++;
        if ({pw1, pw3} !== 2'b11) $display("FAIL lu_r0: got %b want 11", {pw1, pw3});
        else n_pass++;
    endtask

    task automatic test_load_use_3();
        logic [15:0] exp_sc;
        do_reset();
        hazard_on();
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (ctl3 !== ((i < 3) ? 6'b001000 : 6'b110000))
                $display("FAIL lu3_cycle%0d: got %b want %b", i, ctl3, (i < 3) ? 6'b001000 : 6'b110000);
            else n_pass++;
            if (i < 3) begin
                tick();
                idex_memread = 1'b0;
            end
        end
`ifdef HAZARD_STATS_EN
        exp_sc = 16'd3;
`else
        exp_sc = 16'd0;
`endif
        n_checks++;
        if (sc3 !== exp_sc) $display("FAIL lu3_stall_count: got %0d want %0d", sc3, exp_sc);
        else n_pass++;
    endtask

    task automatic test_branch_in_stall();
        do_reset();
        hazard_on();
        tick();
        idex_memread = 1'b0;
        exmem_branch = 1'b1; exmem_zero = 1'b1;
        #1;
        n_checks++;
        if (ctl3 !== 6'b110111) $display("FAIL br_stall_flush: got %b want 110111", ctl3);
        else n_pass++;
        tick();
        exmem_branch = 1'b0; exmem_zero = 1'b0;
        #1;
        n_checks++;
        if (ctl3 !== 6'b110000) $display("FAIL br_stall_run: got %b want 110000", ctl3);
        else n_pass++;

        do_reset();
        hazard_on();
        exmem_branch = 1'b1; exmem_zero = 1'b1;
        #1;
        n_checks++;
        if ({ctl1, ctl3} !== 12'b110111_110111) $display("FAIL br_over_lu: got %b want 110111110111", {ctl1, ctl3});
        else n_pass++;
        tick();
        idle();
        #1;
        n_checks++;
        if (ctl3 !== 6'b110000) $display("FAIL br_over_lu_run: got %b want 110000", ctl3);
        else n_pass++;
        exmem_branch = 1'b1; exmem_zero = 1'b0;
        #1;
        n_checks++;
        if (ctl1 !== 6'b110000) $display("FAIL br_not_taken: got %b want 110000", ctl1);
        else n_pass++;
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        hazard_on();
        tick();
        idex_memread = 1'b0;
        #1;
        n_checks++;
        if (pw3 !== 1'b0) $display("FAIL mid_stall_pre: got %b want 0", pw3);
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (ctl3 !== 6'b110000) $display("FAIL mid_stall_rst: got %b want 110000", ctl3);
        else n_pass++;
        n_checks++;
        if ({sc3, fc3} !== 32'd0) $display("FAIL mid_stall_counters: got %h want 0", {sc3, fc3});
        else n_pass++;
    endtask

    task automatic test_flush_saturate();
        logic [15:0] exp_fc;
        do_reset();
        exmem_branch = 1'b1; exmem_zero = 1'b1;
        repeat (5) tick();
`ifdef HAZARD_STATS_EN
        exp_fc = 16'd5;
`else
        exp_fc = 16'd0;
`endif
        n_checks++;
        if (fc1 !== exp_fc) $display("FAIL flush_count5: got %0d want %0d", fc1, exp_fc);
        else n_pass++;
`ifdef HAZARD_STATS_EN
        repeat (65530) tick();
        n_checks++;
        if (fc1 !== 16'hFFFF) $display("FAIL flush_count_max: got %h want ffff", fc1);
        else n_pass++;
        repeat (4465) tick();
        n_checks++;
        if ({fc1, fc3} !== 32'hFFFF_FFFF) $display("FAIL flush_count_sat: got %h want ffffffff", {fc1, fc3});
        else n_pass++;
        n_checks++;
        if (sc1 !== 16'd0) $display("FAIL flush_stall_count: got %0d want 0", sc1);
        else n_pass++;
`endif
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_forward();
        test_load_use_1();
        test_load_use_3();
        test_branch_in_stall();
        test_reset_mid_stall();
        test_flush_saturate();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core. It watches the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, generates the forwarding selects for both ALU operands in the execute stage, and inserts load-use bubbles, including multi-cycle bubbles through a small stall state machine. It also flushes the younger stages when a branch resolves taken in MEM. It is the only block that drives PC/IF-ID write enables and stage flushes.

## Interface
Parameters:
- LOAD_STALL, 1, bubbles inserted per load-use hazard; legal range 1..7.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- id_rs, id_rt  in  5 each  source registers of the instruction in IF/ID.
- id_uses_rt  in  1  IF/ID instruction reads rt (R-type, beq, sw).
- idex_rs, idex_rt  in  5 each  source registers of the instruction in ID/EX.
- idex_memread  in  1  ID/EX holds a load.
- idex_dest  in  5  destination register of the ID/EX instruction.
- exmem_regwrite  in  1  EX/MEM instruction writes the register file.
- exmem_dest  in  5  EX/MEM destination register.
- memwb_regwrite  in  1  MEM/WB instruction writes the register file.
- memwb_dest  in  5  MEM/WB destination register.
- exmem_branch, exmem_zero  in  1 each  branch control and ALU zero from EX/MEM.
- fwd_a, fwd_b  out  2 each  ALU operand A/B source select.
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID load enable.
- idex_bubble  out  1  zero the ID/EX control fields (wb, mem, execute).
- flush_ifid, flush_idex, flush_exmem  out  1 each  clear the stage's control fields.
- stall_count, flush_count  out  16 each  event counters (see Configuration).

## Operation
- take = exmem_branch & exmem_zero.
- load_use = idex_memread & (idex_dest != 0) & ((idex_dest == id_rs) | (id_uses_rt & (idex_dest == id_rt))).
- Forwarding is combinational. Operand A uses idex_rs:
  - fwd_a = 2'b10 if exmem_regwrite, exmem_dest != 0 and exmem_dest == idex_rs.
  - otherwise 2'b01 if memwb_regwrite, memwb_dest != 0 and memwb_dest == idex_rs.
  - otherwise 2'b00.
  - EX/MEM always wins over MEM/WB. Register 0 is never forwarded.
- fwd_b uses the same rules with idex_rt.
- FSM states are RUN and STALL, with a 3-bit down-counter cnt.
- RUN:
  - If take: flush_ifid = flush_idex = flush_exmem = 1 and pc_write = ifid_write = 1. Stay in RUN. A concurrent load_use is ignored.
  - Else if load_use: pc_write = ifid_write = 0 and idex_bubble = 1. If LOAD_STALL > 1, go to STALL with cnt <= LOAD_STALL-1; otherwise stay in RUN.
  - Else: pc_write = ifid_write = 1, and all other control outputs are 0.
- STALL:
  - pc_write = ifid_write = 0 and idex_bubble = 1. cnt decrements each cycle; leave for RUN when cnt == 1.
  - If take: the flush wins. All three flushes are asserted, pc_write = ifid_write = 1 and idex_bubble = 0. Go to RUN with cnt <= 0.
- Downstream stages keep advancing during a stall; only PC and IF/ID freeze.

## Timing
- Forwarding, stall and flush outputs are combinational from the current inputs and state, so they act in the same cycle.
- Reset state: RUN, cnt = 0, counters = 0.
- Outputs in that state with idle inputs: fwd_a = fwd_b = 00, pc_write = ifid_write = 1, and all bubble and flush outputs are 0.
- rst asserted mid-stall: the next cycle is RUN with pc_write = 1.
- A load-use hazard costs exactly LOAD_STALL cycles with pc_write = 0.
- A taken branch costs one flush cycle.

## Configuration
- HAZARD_STATS_EN defined:
  - stall_count increments on every cycle with pc_write = 0.
  - flush_count increments on every cycle with take.
  - Both are 16-bit, saturate at 16'hFFFF, and are cleared by rst.
- HAZARD_STATS_EN undefined: both outputs are tied to 16'd0 and no counter flops exist.

## Structure
- Shared package hazard_pkg holds:
  - FSM state enum (RUN, STALL).
  - Forward select constants FWD_REG = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10, matching the execute-stage operand mux encoding.
- Sub-module fwd_sel is the combinational comparator producing one 2-bit select. It is instantiated twice, once for operand A and once for operand B.

## Test plan
- exmem_regwrite = 1, exmem_dest = 5, memwb_regwrite = 1, memwb_dest = 5, idex_rs = 5 -> fwd_a = 10. Same with exmem_dest = 0 -> fwd_a = 01.
- LOAD_STALL = 1, idex_memread = 1, idex_dest = 8, id_rs = 8 -> one cycle with pc_write = 0 and idex_bubble = 1. With id_uses_rt = 0 and only id_rt = 8 -> no stall.
- LOAD_STALL = 3, same hazard -> exactly 3 consecutive cycles with pc_write = 0, then pc_write = 1. stall_count = 3 with HAZARD_STATS_EN.
- exmem_branch = 1, exmem_zero = 1 in the second STALL cycle -> all flushes = 1, pc_write = 1, idex_bubble = 0 that cycle, and the next cycle is RUN.
- rst pulsed during STALL -> the next cycle has pc_write = 1, all flushes = 0, and counters = 0.
- Force 70000 flush cycles with HAZARD_STATS_EN -> flush_count holds at 16'hFFFF.
